// File: rtl/shift_pkg.sv
// Shared constants for the shift command sequencer and its shifter bench.
// Opcodes, FSM state encoding and datapath widths.
package shift_pkg;

  localparam int WIDTH = 32;
  localparam int AMT_W = 5;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS1 = 2'd1,
    ST_PASS2 = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic is_rsvd(
    input logic [2:0] op
  );
    return op > OP_ROR;
  endfunction

endpackage

// File: rtl/shift_op_sequencer.sv
// Issue stage for a logical barrel shifter: builds SLL/SRL/SRA/ROL/ROR
// from one or two shifter passes and hands the result on via valid/ready.
// Ports: CLK, RST_N (async low); IN_VALID/IN_READY/IN_OP/IN_AMT/IN_DATA
// command side; SH_DIR/SH_AMT/SH_DIN/SH_DOUT shifter side;
// OUT_VALID/OUT_READY/OUT_DATA/OUT_ERR result side.
module shift_op_sequencer
  import shift_pkg::*;
(
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [2:0]       IN_OP,
  input  logic [AMT_W-1:0] IN_AMT,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             SH_DIR,
  output logic [AMT_W-1:0] SH_AMT,
  output logic [WIDTH-1:0] SH_DIN,
  input  logic [WIDTH-1:0] SH_DOUT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_ERR
);

  state_t           state;
  state_t           nxt;
  logic [2:0]       op_q;
  logic [AMT_W-1:0] amt_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] acc_q;

  logic             amt_nz;
  logic             two_pass;
  logic [AMT_W-1:0] amt_inv;
  logic [WIDTH-1:0] fin2;

  assign IN_READY = (state == ST_IDLE);
  assign amt_nz   = |amt_q;

  // Rotates with a zero amount collapse to the identity, and a
  // non-negative SRA needs no sign fill, so both stay single pass.
  assign two_pass = amt_nz &
    ((op_q == OP_ROL) || (op_q == OP_ROR) ||
     ((op_q == OP_SRA) && data_q[WIDTH-1]));

  // Only meaningful in PASS2, which is only reached with amt != 0.
  assign amt_inv = AMT_W'(6'd32 - {1'b0, amt_q});

  // SRA pass 2 shifts an all-ones mask; its complement is the sign fill.
  assign fin2 = (op_q == OP_SRA) ? (acc_q | ~SH_DOUT)
                                 : (acc_q | SH_DOUT);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      amt_q     <= '0;
      data_q    <= '0;
      acc_q     <= '0;
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      OUT_ERR   <= 1'b0;
    end else begin
      state <= nxt;
      unique case (state)
        ST_IDLE: begin
          if (IN_VALID) begin
            op_q   <= IN_OP;
            amt_q  <= IN_AMT;
            data_q <= IN_DATA;
          end
        end
        ST_PASS1: begin
          acc_q <= SH_DOUT;
          if (!two_pass) begin
            OUT_VALID <= 1'b1;
            OUT_DATA  <= SH_DOUT;
            OUT_ERR   <= is_rsvd(op_q);
          end
        end
        ST_PASS2: begin
          OUT_VALID <= 1'b1;
          OUT_DATA  <= fin2;
          OUT_ERR   <= 1'b0;
        end
        ST_DONE: begin
          if (OUT_READY) OUT_VALID <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:  if (IN_VALID) nxt = ST_PASS1;
      ST_PASS1: nxt = two_pass ? ST_PASS2 : ST_DONE;
      ST_PASS2: nxt = ST_DONE;
      ST_DONE:  if (OUT_READY) nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    SH_DIR = 1'b0;
    SH_AMT = '0;
    SH_DIN = '0;
    unique case (state)
      ST_PASS1: begin
        SH_DIN = data_q;
        SH_AMT = is_rsvd(op_q) ? '0 : amt_q;
        SH_DIR = (op_q == OP_SRL) ||
                 (op_q == OP_SRA) ||
                 (op_q == OP_ROR);
      end
      ST_PASS2: begin
        unique case (1'b1)
          (op_q == OP_ROL): begin
            SH_DIR = 1'b1;
            SH_AMT = amt_inv;
            SH_DIN = data_q;
          end
          (op_q == OP_ROR): begin
            SH_DIR = 1'b0;
            SH_AMT = amt_inv;
            SH_DIN = data_q;
          end
          default: begin
            SH_DIR = 1'b1;
            SH_AMT = amt_q;
            SH_DIN = '1;
          end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shift_op_sequencer.sv
// Bench for shift_op_sequencer paired with a behavioural logical shifter.
// Directed table, hold/reset sequences, then random commands vs a model.
module tb_shift_op_sequencer;
  import shift_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [AMT_W-1:0] in_amt;
  logic [WIDTH-1:0] in_data;
  logic             sh_dir;
  logic [AMT_W-1:0] sh_amt;
  logic [WIDTH-1:0] sh_din;
  logic [WIDTH-1:0] sh_dout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign sh_dout = sh_dir ? (sh_din >> sh_amt) : (sh_din << sh_amt);

  shift_op_sequencer dut (
    .CLK(clk), .RST_N(rst_n),
    .IN_VALID(in_valid), .IN_READY(in_ready),
    .IN_OP(in_op), .IN_AMT(in_amt), .IN_DATA(in_data),
    .SH_DIR(sh_dir), .SH_AMT(sh_amt), .SH_DIN(sh_din),
    .SH_DOUT(sh_dout),
    .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .OUT_DATA(out_data), .OUT_ERR(out_err)
  );

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  amt;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  // Rotation/shift semantics written straight from the op definitions.
  function automatic logic [31:0] ref_res(input logic [2:0] op,
    input logic [4:0] amt, input logic [31:0] d);
    int a;
    a = int'(amt);
    case (op)
      OP_SLL: return d << a;
      OP_SRL: return d >> a;
      OP_SRA: return 32'($signed(d) >>> a);
      OP_ROL: return (a == 0) ? d : ((d << a) | (d >> (32 - a)));
      OP_ROR: return (a == 0) ? d : ((d >> a) | (d << (32 - a)));
      default: return d;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op,
    input logic [4:0] amt, input logic [31:0] d);
    if (amt == 0) return 2;
    if (op == OP_ROL || op == OP_ROR) return 3;
    if (op == OP_SRA && d[31]) return 3;
    return 2;
  endfunction

  // Latency counts rising edges from the accept edge (inclusive) to the
  // edge after which OUT_VALID is seen high. Leaves the result waiting.
  task automatic issue(input logic [2:0] op, input logic [4:0] amt,
                       input logic [31:0] d, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: in_ready %b want 1", in_ready);
    end
    in_valid = 1'b1;
    in_op = op;
    in_amt = amt;
    in_data = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic accept_out;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_cmd(input string nm, input logic [2:0] op,
    input logic [4:0] amt, input logic [31:0] d,
    input logic [31:0] ed, input logic ee, input int el);
    int lat;
    issue(op, amt, d, lat);
    chk({nm, "_data"}, out_data, ed);
    chk({nm, "_err"}, 32'(out_err), 32'(ee));
    chk({nm, "_lat"}, 32'(lat), 32'(el));
    accept_out();
  endtask

  initial begin
    int lat;
    logic [31:0] held;
    logic [2:0]  r_op;
    logic [4:0]  r_amt;
    logic [31:0] r_d;

    tbl[0]  = '{OP_SLL, 5'd4,  32'h0000_0001, 32'h0000_0010, 1'b0, 2};
    tbl[1]  = '{OP_SRA, 5'd4,  32'h8000_0000, 32'hF800_0000, 1'b0, 3};
    tbl[2]  = '{OP_SRA, 5'd4,  32'h4000_0000, 32'h0400_0000, 1'b0, 2};
    tbl[3]  = '{OP_ROL, 5'd1,  32'h8000_0001, 32'h0000_0003, 1'b0, 3};
    tbl[4]  = '{OP_ROR, 5'd4,  32'h0000_00F1, 32'h1000_000F, 1'b0, 3};
    tbl[5]  = '{OP_ROR, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 2};
    tbl[6]  = '{3'b110, 5'd7,  32'h1234_5678, 32'h1234_5678, 1'b1, 2};
    tbl[7]  = '{OP_SRL, 5'd31, 32'h8000_0000, 32'h0000_0001, 1'b0, 2};
    tbl[8]  = '{OP_SRA, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3};
    tbl[9]  = '{OP_ROL, 5'd31, 32'h1234_5678, 32'h091A_2B3C, 1'b0, 3};
    tbl[10] = '{3'b111, 5'd0,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 2};
    tbl[11] = '{OP_SRA, 5'd0,  32'h8000_0000, 32'h8000_0000, 1'b0, 2};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_op = '0;
    in_amt = '0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_sh", {sh_dir, sh_amt, 26'(sh_din)}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].amt,
              tbl[i].data, tbl[i].exp_data, tbl[i].exp_err,
              tbl[i].exp_lat);

    // Back-pressure in DONE: result held, new command ignored.
    issue(OP_SLL, 5'd8, 32'h0000_00AB, lat);
    held = out_data;
    chk("hold_first", held, 32'h0000_AB00);
    @(negedge clk);
    in_valid = 1'b1;
    in_op = OP_SRL;
    in_amt = 5'd1;
    in_data = 32'hFFFF_0000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold_data%0d", i), out_data, held);
      chk($sformatf("hold_valid%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("hold_rdy%0d", i), 32'(in_ready), 32'd0);
      chk($sformatf("hold_sh%0d", i), sh_din, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("hold_rel_valid", 32'(out_valid), 32'd0);
    chk("hold_rel_rdy", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("hold_ignored", 32'(in_ready), 32'd1);

    // Reset while the ROL is in its second pass.
    @(negedge clk);
    in_valid = 1'b1;
    in_op = OP_ROL;
    in_amt = 5'd3;
    in_data = 32'hF000_000F;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_pass2_dir", 32'(sh_dir), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd("post_rst_srl", OP_SRL, 5'd4, 32'hF000_0000,
            32'h0F00_0000, 1'b0, 2);

    // Random back-to-back commands against the model.
    for (int i = 0; i < 200; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_amt = 5'($urandom_range(0, 31));
      r_d = $urandom;
      if (i % 8 == 0) r_amt = 5'd0;
      run_cmd($sformatf("rnd%0d_op%0d", i, r_op), r_op, r_amt, r_d,
              ref_res(r_op, r_amt, r_d), is_rsvd(r_op),
              ref_lat(r_op, r_amt, r_d));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
